// File: rtl/v_value_stream_buf.sv
// Stream-side controller for the v-value RAM: circular FIFO over an external
// registered-read RAM, with a 2-entry skid that hides the read latency.
module v_value_stream_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH:0]   level
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [CW-1:0]         ram_count, cnt_nxt, level_q, level_nxt;
  logic                  inflight, wr, pop, rd_issue;
  logic [1:0]            skid_occ, occ_nxt;
  logic [DATA_WIDTH-1:0] skid0, skid1;

  assign in_ready = !rst && !flush && (ram_count != DEPTH);
  assign wr       = in_valid && in_ready;
  assign pop      = (skid_occ != 2'd0) && out_ready;

  // Skid space counts the same-cycle pop, so a full-rate stream keeps one
  // read in flight every cycle; the skid still never exceeds 2 entries.
  assign rd_issue = (ram_count != '0) &&
                    ((skid_occ + {1'b0, inflight} - {1'b0, pop}) < 2'd2);

  assign cnt_nxt   = ram_count + CW'(wr) - CW'(rd_issue);
  assign occ_nxt   = skid_occ + {1'b0, inflight} - {1'b0, pop};
  assign level_nxt = cnt_nxt + CW'(rd_issue) + CW'(occ_nxt);

  assign ram_data       = in_data;
  assign ram_we         = wr;
  assign ram_write_addr = wptr;
  assign ram_read_addr  = rptr;
  assign out_valid      = (skid_occ != 2'd0);
  assign out_data       = skid0;
  assign level          = level_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
      skid_occ  <= 2'd0;
      level_q   <= '0;
    end else begin
      if (wr)       wptr <= wptr + 1'b1;
      if (rd_issue) rptr <= rptr + 1'b1;
      ram_count <= cnt_nxt;
      inflight  <= rd_issue;
      skid_occ  <= occ_nxt;
      level_q   <= level_nxt;
      // skid0 is the head; skid1 only holds data while two entries are queued
      case ({inflight, pop})
        2'b10: if (skid_occ == 2'd0) skid0 <= ram_q;
               else                  skid1 <= ram_q;
        2'b01: skid0 <= skid1;
        2'b11: if (skid_occ == 2'd1) skid0 <= ram_q;
               else begin
                 skid0 <= skid1;
                 skid1 <= ram_q;
               end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_v_value_stream_buf.sv
// Bench for v_value_stream_buf: behavioural RAM plus a queue scoreboard of
// accepted-but-undelivered v-values.
module tb_v_value_stream_buf;
  localparam int DW = 8;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, ram_we;
  logic [DW-1:0] out_data, ram_data, ram_q;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic [AW:0]   level;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  v_value_stream_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_data(ram_data), .ram_write_addr(ram_write_addr),
    .ram_read_addr(ram_read_addr), .ram_we(ram_we), .ram_q(ram_q),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  // One clock: sample handshakes mid-cycle, record accepted input, return at edge+1.
  task automatic tick(output bit i_f, output bit o_f, output logic [DW-1:0] o_d);
    @(negedge clk);
    i_f = in_valid && in_ready;
    o_f = out_valid && out_ready;
    o_d = out_data;
    if (i_f) exp_q.push_back(in_data);
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || ram_we !== 1'b0 || out_valid !== 1'b0 || level !== 0) begin
        errors++;
        $display("FAIL reset_state: in_ready=%b ram_we=%b out_valid=%b level=%0d, need 0 0 0 0",
                 in_ready, ram_we, out_valid, level);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: in_ready=%b need 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    in_data = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_write_addr !== 0) begin
      errors++; $display("FAIL lat_write: ram_we=%b waddr=%0d need 1 0", ram_we, ram_write_addr);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || level !== 1 || ram_read_addr !== 0) begin
      errors++;
      $display("FAIL lat_cycle1: out_valid=%b level=%0d raddr=%0d need 0 1 0",
               out_valid, level, ram_read_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || ram_read_addr !== 1) begin
      errors++; $display("FAIL lat_cycle2: out_valid=%b raddr=%0d need 0 1", out_valid, ram_read_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      errors++; $display("FAIL lat_data: out_valid=%b out_data=%h need 1 5a", out_valid, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || level !== 0) begin
      errors++; $display("FAIL lat_drain: out_valid=%b level=%0d need 0 0", out_valid, level);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    int n_in = 0, n_out = 0, cyc = 0;
    bit i_f, o_f, started = 0;
    logic [DW-1:0] d, e;
    logic [31:0] v;
    out_ready = 1'b1;
    while (n_out < 256 && cyc < 600) begin
      in_valid = (n_in < 256);
      v = n_in;
      in_data = v[DW-1:0];
      tick(i_f, o_f, d);
      cyc++;
      if (i_f) n_in++;
      if (started) begin
        checks++;
        if (!o_f) begin errors++; $display("FAIL stream_bubble: no beat after %0d outputs", n_out); end
      end
      if (o_f) begin
        started = 1;
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL stream_data: got %h need %h", d, e); end
        n_out++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_out != 256) begin errors++; $display("FAIL stream_count: got %0d need 256", n_out); end
  endtask

  task automatic test_full();
    int n_acc = 0, cyc = 0, rise = -1;
    bit i_f, o_f, first = 1;
    logic [DW-1:0] d, e;
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (140) begin
      in_data = DW'($urandom);
      tick(i_f, o_f, d);
      if (i_f) n_acc++;
    end
    checks++;
    if (n_acc != 130 || in_ready !== 1'b0 || level !== 130) begin
      errors++;
      $display("FAIL full_fill: accepted=%0d in_ready=%b level=%0d need 130 0 130", n_acc, in_ready, level);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 300) begin
      tick(i_f, o_f, d);
      cyc++;
      if (rise < 0 && in_ready === 1'b1) rise = cyc;
      if (first) begin
        first = 0;
        checks++;
        if (!o_f) begin errors++; $display("FAIL full_first_valid: out_valid=0 need 1"); end
      end
      if (o_f) begin
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL full_data: got %h need %h", d, e); end
      end
    end
    checks++;
    if (rise < 1 || rise > 2) begin errors++; $display("FAIL full_ready_rise: cycle %0d need 1..2", rise); end
    checks++;
    if (exp_q.size() != 0 || level !== 0) begin
      errors++; $display("FAIL full_drain: left=%0d level=%0d need 0 0", exp_q.size(), level);
    end
  endtask

  task automatic test_backpressure();
    int n_in = 0, n_out = 0, cyc = 0;
    bit i_f, o_f;
    logic [DW-1:0] d, e;
    do_flush();
    while (n_out < 1000 && cyc < 6000) begin
      in_valid = (n_in < 1000);
      in_data = DW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick(i_f, o_f, d);
      cyc++;
      if (i_f) n_in++;
      if (o_f) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_spurious: output %h with nothing outstanding", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e) begin errors++; $display("FAIL bp_data: got %h need %h", d, e); end
        end
      end
      checks++;
      if (level !== (AW+1)'(exp_q.size())) begin
        errors++; $display("FAIL bp_level: got %0d need %0d", level, exp_q.size());
      end
      if (exp_q.size() < 128) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL bp_ready: in_ready=%b with %0d outstanding", in_ready, exp_q.size());
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_out != 1000) begin errors++; $display("FAIL bp_count: got %0d need 1000", n_out); end
  endtask

  task automatic test_flush();
    bit i_f, o_f, seen = 0;
    logic [DW-1:0] d, e, v;
    do_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (5) begin in_data = DW'($urandom); tick(i_f, o_f, d); end
    in_valid = 1'b0;
    repeat (3) tick(i_f, o_f, d);
    // pop one and write one together so a read is issued and level stays 5
    out_ready = 1'b1; in_valid = 1'b1; in_data = DW'($urandom);
    tick(i_f, o_f, d);
    if (o_f) begin
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL flush_pre_data: got %h need %h", d, e); end
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 5 || in_ready !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: level=%0d in_ready=%b ram_we=%b need 5 0 0", level, in_ready, ram_we);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || level !== 0) begin
        errors++; $display("FAIL flush_clear: out_valid=%b level=%0d need 0 0", out_valid, level);
      end
      @(posedge clk); #1;
    end
    v = DW'($urandom);
    in_data = v; in_valid = 1'b1; out_ready = 1'b1;
    tick(i_f, o_f, d);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(i_f, o_f, d);
      if (o_f) begin
        seen = 1;
        checks++;
        if (d !== v) begin errors++; $display("FAIL flush_first_out: got %h need %h", d, v); end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL flush_timeout: got no output need %h", v); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_streaming();
    test_full();
    test_backpressure();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
